mipi_tx_frame_ctrl: RTL and testbench

//  Sequences the Efinix MIPI CSI-2 TX hard block (my_mipi_tx_*) in the tx_pixel_clk domain.

---
 rtl/mipi_tx_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mipi_tx_frame_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_tx_frame_ctrl.sv
// MIPI CSI-2 TX frame sequencer: reset hold, VSYNC/HSYNC/VALID framing
// and a one-beat registered pixel datapath in the tx_pixel_clk domain.
module mipi_tx_frame_ctrl #(
    parameter int          H_ACTIVE     = 1920,
    parameter int          V_ACTIVE     = 1080,
    parameter int          PIX_PER_BEAT = 8,
    parameter logic [5:0]  DATA_TYPE    = 6'h2A,
    parameter logic [1:0]  NUM_LANES    = 2'b11,
    parameter int          RST_CYCLES   = 1024,
    parameter int          VSYNC_W      = 4,
    parameter int          HSYNC_W      = 4,
    parameter int          H_BLANK      = 64,
    parameter int          V_BLANK      = 16
) (
    input  logic        tx_pixel_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        my_mipi_tx_RSTN,
    output logic        my_mipi_tx_DPHY_RSTN,
    output logic        my_mipi_tx_VSYNC,
    output logic        my_mipi_tx_HSYNC,
    output logic        my_mipi_tx_VALID,
    output logic [63:0] my_mipi_tx_DATA,
    output logic [15:0] my_mipi_tx_HRES,
    output logic [5:0]  my_mipi_tx_TYPE,
    output logic [1:0]  my_mipi_tx_LANES,
    output logic [1:0]  my_mipi_tx_VC,
    output logic        my_mipi_tx_FRAME_MODE,
    output logic [15:0] frame_cnt,
    output logic        underrun,
    output logic        busy
);

    localparam int BEATS  = H_ACTIVE / PIX_PER_BEAT;
    localparam int VB_CYC = V_BLANK * (HSYNC_W + H_BLANK);
    localparam int M1 = (RST_CYCLES > VB_CYC) ? RST_CYCLES : VB_CYC;
    localparam int M2 = (VSYNC_W > HSYNC_W) ? VSYNC_W : HSYNC_W;
    localparam int M3 = (M2 > H_BLANK) ? M2 : H_BLANK;
    localparam int CNT_MAX = (M1 > M3) ? M1 : M3;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int BW = $clog2(BEATS + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_W - 1);
    localparam logic [CW-1:0] HS_LAST  = CW'(HSYNC_W - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(VB_CYC - 1);
    localparam logic [LW-1:0] LN_LAST  = LW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BT_LAST  = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        RST_HOLD, IDLE, VS, HS, ACT, HB, VB
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] line;
    logic [BW-1:0] beat;

    assign my_mipi_tx_HRES       = 16'(H_ACTIVE);
    assign my_mipi_tx_TYPE       = DATA_TYPE;
    assign my_mipi_tx_LANES      = NUM_LANES;
    assign my_mipi_tx_VC         = 2'b00;
    assign my_mipi_tx_FRAME_MODE = 1'b0;

    always_ff @(posedge tx_pixel_clk or posedge rst) begin
        if (rst) begin
            state                <= RST_HOLD;
            cnt                  <= '0;
            line                 <= '0;
            beat                 <= '0;
            src_ready            <= 1'b0;
            my_mipi_tx_RSTN      <= 1'b0;
            my_mipi_tx_DPHY_RSTN <= 1'b0;
            my_mipi_tx_VSYNC     <= 1'b0;
            my_mipi_tx_HSYNC     <= 1'b0;
            my_mipi_tx_VALID     <= 1'b0;
            my_mipi_tx_DATA      <= '0;
            frame_cnt            <= '0;
            underrun             <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            my_mipi_tx_VALID <= 1'b0;
            unique case (state)
                RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        my_mipi_tx_RSTN      <= 1'b1;
                        my_mipi_tx_DPHY_RSTN <= 1'b1;
                        cnt                  <= '0;
                        state                <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (enable) begin
                        my_mipi_tx_VSYNC <= 1'b1;
                        busy             <= 1'b1;
                        cnt              <= '0;
                        state            <= VS;
                    end
                end
                VS: begin
                    if (cnt == VS_LAST) begin
                        my_mipi_tx_VSYNC <= 1'b0;
                        my_mipi_tx_HSYNC <= 1'b1;
                        line             <= '0;
                        cnt              <= '0;
                        state            <= HS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HS: begin
                    if (cnt == HS_LAST) begin
                        my_mipi_tx_HSYNC <= 1'b0;
                        src_ready        <= 1'b1;
                        beat             <= '0;
                        cnt              <= '0;
                        state            <= ACT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACT: begin
                    // src_ready is high throughout ACT, so src_valid is the handshake
                    if (!src_valid) begin
                        underrun <= 1'b1;
                    end else begin
                        my_mipi_tx_DATA  <= src_data;
                        my_mipi_tx_VALID <= 1'b1;
                        if (beat == BT_LAST) begin
                            src_ready <= 1'b0;
                            state     <= HB;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                HB: begin
                    if (cnt == HB_LAST) begin
                        cnt <= '0;
                        if (line == LN_LAST) begin
                            state <= VB;
                        end else begin
                            line             <= line + 1'b1;
                            my_mipi_tx_HSYNC <= 1'b1;
                            state            <= HS;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VB: begin
                    if (cnt == VB_LAST) begin
                        cnt       <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                        if (enable) begin
                            my_mipi_tx_VSYNC <= 1'b1;
                            state            <= VS;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_tx_frame_ctrl.sv
// Directed bench for mipi_tx_frame_ctrl with a reduced 64x4 frame:
// per-frame vector table plus reset-hold, abort and counter-wrap sequences.
module tb_mipi_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [63:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        rstn, dphy_rstn, vsync, hsync, valid;
    logic [63:0] data;
    logic [15:0] hres;
    logic [5:0]  dtype;
    logic [1:0]  lanes, vc;
    logic        fmode;
    logic [15:0] frame_cnt;
    logic        underrun, busy;

    int checks = 0;
    int failures = 0;

    mipi_tx_frame_ctrl #(
        .H_ACTIVE(64), .V_ACTIVE(4)
    ) dut (
        .tx_pixel_clk(clk), .rst(rst), .enable(enable),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .my_mipi_tx_RSTN(rstn), .my_mipi_tx_DPHY_RSTN(dphy_rstn),
        .my_mipi_tx_VSYNC(vsync), .my_mipi_tx_HSYNC(hsync),
        .my_mipi_tx_VALID(valid), .my_mipi_tx_DATA(data),
        .my_mipi_tx_HRES(hres), .my_mipi_tx_TYPE(dtype),
        .my_mipi_tx_LANES(lanes), .my_mipi_tx_VC(vc),
        .my_mipi_tx_FRAME_MODE(fmode),
        .frame_cnt(frame_cnt), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Source model: sequential beats, optionally alternating src_valid
    logic [63:0] exp_q[$];
    logic [31:0] seq = 32'h100;
    bit          toggle_mode = 1'b0;
    bit          hs_prev = 1'b0;

    initial begin
        src_valid = 1'b1;
        src_data  = {~seq, seq};
    end

    always @(posedge clk) begin
        hs_prev = src_valid && src_ready;
        if (hs_prev) begin
            exp_q.push_back(src_data);
            seq = seq + 1;
        end
        #1;
        src_valid = toggle_mode ? ~src_valid : 1'b1;
        src_data  = {~seq, seq};
    end

    // Output monitor
    int  vs_cyc, hs_cyc, hs_pulses, n_valid, n_cyc;
    bit  hs_last = 1'b0;

    task automatic zero_counts();
        vs_cyc = 0; hs_cyc = 0; hs_pulses = 0; n_valid = 0; n_cyc = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_latency", 64'(valid), 64'(hs_prev));
            if (int'(valid) + int'(hsync) + int'(vsync) > 1)
                chk("sync_exclusive", 64'({valid, hsync, vsync}), 64'd0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("data_unexpected", data, 64'd0);
                end else begin
                    chk("data_order", data, exp_q.pop_front());
                end
            end
            n_cyc++;
            vs_cyc += int'(vsync);
            hs_cyc += int'(hsync);
            n_valid += int'(valid);
            if (hsync && !hs_last) hs_pulses++;
            hs_last = hsync;
        end
    end

    typedef struct {
        bit          toggle;
        bit          drop_en;
        int          exp_hs;
        int          exp_valid;
        int          exp_vs;
        int          exp_cyc;
        bit          exp_underrun;
        bit          exp_busy;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[4];

    task automatic measure_rst_hold();
        int n = 0;
        while (rstn !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            chk("dphy_tracks_rstn", 64'(dphy_rstn), 64'(rstn));
        end
        chk("rst_hold_cycles", 64'(n), 64'd1024);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rstn"}, 64'(rstn), 64'd0);
        chk({tag, "_dphy"}, 64'(dphy_rstn), 64'd0);
        chk({tag, "_vsync"}, 64'(vsync), 64'd0);
        chk({tag, "_hsync"}, 64'(hsync), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_data"}, data, 64'd0);
        chk({tag, "_ready"}, 64'(src_ready), 64'd0);
        chk({tag, "_fcnt"}, 64'(frame_cnt), 64'd0);
        chk({tag, "_underrun"}, 64'(underrun), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [15:0] prev_fc;
        int          n;
        vecs[0] = '{0, 0, 4, 32, 4, 1397, 0, 1, 16'd1};
        vecs[1] = '{1, 0, 4, 32, 4, 0,    1, 1, 16'd2};
        vecs[2] = '{0, 0, 4, 32, 4, 1396, 1, 1, 16'd3};
        vecs[3] = '{0, 1, 4, 32, 4, 1396, 1, 0, 16'd4};
        zero_counts();

        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("hres", 64'(hres), 64'd64);
        chk("type", 64'(dtype), 64'h2A);
        chk("lanes", 64'(lanes), 64'd3);
        chk("vc", 64'(vc), 64'd0);
        chk("frame_mode", 64'(fmode), 64'd0);

        rst = 1'b0;
        measure_rst_hold();
        zero_counts();

        for (int i = 0; i < 4; i++) begin
            toggle_mode = vecs[i].toggle;
            prev_fc = frame_cnt;
            n = 0;
            while (frame_cnt === prev_fc && n < 4000) begin
                @(posedge clk); #1;
                n++;
                if (vecs[i].drop_en && hs_pulses >= 2) enable = 1'b0;
            end
            chk("frame_timeout", 64'(n < 4000), 64'd1);
            chk("frame_hs_pulses", 64'(hs_pulses), 64'(vecs[i].exp_hs));
            chk("frame_hs_cycles", 64'(hs_cyc), 64'(vecs[i].exp_hs * 4));
            chk("frame_valid", 64'(n_valid), 64'(vecs[i].exp_valid));
            chk("frame_vs_cycles", 64'(vs_cyc), 64'(vecs[i].exp_vs));
            if (vecs[i].exp_cyc != 0)
                chk("frame_cycles", 64'(n_cyc), 64'(vecs[i].exp_cyc));
            chk("frame_underrun", 64'(underrun), 64'(vecs[i].exp_underrun));
            chk("frame_busy", 64'(busy), 64'(vecs[i].exp_busy));
            chk("frame_cnt", 64'(frame_cnt), 64'(vecs[i].exp_fc));
            zero_counts();
        end

        // enable was dropped mid-frame: controller must stay idle
        repeat (50) @(posedge clk);
        #1;
        chk("idle_vsync", 64'(vs_cyc), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_fcnt", 64'(frame_cnt), 64'd4);
        chk("idle_ready", 64'(src_ready), 64'd0);

        // reset mid-ACT aborts at once and restarts the full hold
        enable = 1'b1;
        n = 0;
        while (src_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_act", 64'(src_ready), 64'd1);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        hs_prev = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        measure_rst_hold();

        // frame counter wrap
        n = 0;
        while (vsync !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wrap_vsync", 64'(vsync), 64'd1);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt;
        chk("wrap_preload", 64'(frame_cnt), 64'hFFFF);
        n = 0;
        while (frame_cnt === 16'hFFFF && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wrap_zero", 64'(frame_cnt), 64'd0);
        chk("wrap_underrun", 64'(underrun), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
